// File: rtl/sample_discriminator.sv
// Per-channel hysteresis gate for raw ADC words: forwards words while a channel is
// active and emits a {sample_index, timer} timestamp at the start of every burst.
module sample_discriminator #(
  parameter int SAMPLE_WIDTH       = 16,
  parameter int PARALLEL_SAMPLES   = 2,
  parameter int CHANNELS           = 8,
  parameter int TSTAMP_WIDTH       = 64,
  parameter int SAMPLE_INDEX_WIDTH = 16
) (
  input  logic                                    i_adc_clk,
  input  logic                                    i_adc_reset,
  input  logic [CHANNELS*SAMPLE_WIDTH*PARALLEL_SAMPLES-1:0] i_adc_samples_data,
  input  logic [CHANNELS-1:0]                     i_adc_samples_valid,
  input  logic [CHANNELS*2*SAMPLE_WIDTH-1:0]      i_adc_thresholds,
  input  logic                                    i_adc_discriminator_reset,
  output logic [CHANNELS*SAMPLE_WIDTH*PARALLEL_SAMPLES-1:0] o_adc_samples_data,
  output logic [CHANNELS-1:0]                     o_adc_samples_valid,
  output logic [CHANNELS*TSTAMP_WIDTH-1:0]        o_adc_timestamps_data,
  output logic [CHANNELS-1:0]                     o_adc_timestamps_valid
);

  localparam int DATA_WIDTH  = SAMPLE_WIDTH * PARALLEL_SAMPLES;
  localparam int TIMER_WIDTH = TSTAMP_WIDTH - SAMPLE_INDEX_WIDTH;
  localparam logic [TIMER_WIDTH-1:0]        TIMER_ONE = 1;
  localparam logic [SAMPLE_INDEX_WIDTH-1:0] INDEX_ONE = 1;

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t                        r_state      [CHANNELS];
  state_t                        w_next_state [CHANNELS];
  logic [SAMPLE_INDEX_WIDTH-1:0] r_index      [CHANNELS];
  logic [TIMER_WIDTH-1:0]        r_timer;
  logic [CHANNELS-1:0]           w_above;
  logic [CHANNELS-1:0]           w_below;
  logic [CHANNELS-1:0]           w_forward;
  logic [CHANNELS-1:0]           w_trigger;

  logic [CHANNELS*DATA_WIDTH-1:0]   r_samples_data;
  logic [CHANNELS-1:0]              r_samples_valid;
  logic [CHANNELS*TSTAMP_WIDTH-1:0] r_ts_data;
  logic [CHANNELS-1:0]              r_ts_valid;

  function automatic logic any_above(input logic [DATA_WIDTH-1:0] word,
                                     input logic signed [SAMPLE_WIDTH-1:0] thr);
    any_above = 1'b0;
    for (int s = 0; s < PARALLEL_SAMPLES; s++)
      if ($signed(word[s*SAMPLE_WIDTH +: SAMPLE_WIDTH]) > thr) any_above = 1'b1;
  endfunction

  function automatic logic all_below(input logic [DATA_WIDTH-1:0] word,
                                     input logic signed [SAMPLE_WIDTH-1:0] thr);
    all_below = 1'b1;
    for (int s = 0; s < PARALLEL_SAMPLES; s++)
      if (!($signed(word[s*SAMPLE_WIDTH +: SAMPLE_WIDTH]) < thr)) all_below = 1'b0;
  endfunction

  // Threshold pair per channel is {low, high}, high in the lower half.
  always_comb begin
    w_above = '0;
    w_below = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      w_above[ch] = any_above(i_adc_samples_data[ch*DATA_WIDTH +: DATA_WIDTH],
                              $signed(i_adc_thresholds[ch*2*SAMPLE_WIDTH +: SAMPLE_WIDTH]));
      w_below[ch] = all_below(i_adc_samples_data[ch*DATA_WIDTH +: DATA_WIDTH],
                              $signed(i_adc_thresholds[ch*2*SAMPLE_WIDTH+SAMPLE_WIDTH +: SAMPLE_WIDTH]));
    end
  end

  always_comb begin
    w_forward = '0;
    w_trigger = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      w_next_state[ch] = r_state[ch];
      if (i_adc_samples_valid[ch]) begin
        case (r_state[ch])
          S_IDLE: begin
            if (w_above[ch]) begin
              w_next_state[ch] = S_ACTIVE;
              w_forward[ch]    = 1'b1;
              w_trigger[ch]    = 1'b1;
            end
          end
          S_ACTIVE: begin
            // Above wins over below so inverted thresholds cannot end a burst early.
            if (w_above[ch])      w_forward[ch]    = 1'b1;
            else if (w_below[ch]) w_next_state[ch] = S_IDLE;
            else                  w_forward[ch]    = 1'b1;
          end
          default: w_next_state[ch] = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_adc_clk or posedge i_adc_reset) begin
    if (i_adc_reset) begin
      r_timer         <= '0;
      r_samples_data  <= '0;
      r_samples_valid <= '0;
      r_ts_data       <= '0;
      r_ts_valid      <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        r_state[ch] <= S_IDLE;
        r_index[ch] <= '0;
      end
    end else if (i_adc_discriminator_reset) begin
      r_timer         <= '0;
      r_samples_data  <= '0;
      r_samples_valid <= '0;
      r_ts_data       <= '0;
      r_ts_valid      <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        r_state[ch] <= S_IDLE;
        r_index[ch] <= '0;
      end
    end else begin
      if (i_adc_samples_valid[0]) r_timer <= r_timer + TIMER_ONE;
      r_samples_valid <= w_forward;
      r_ts_valid      <= w_trigger;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        r_state[ch] <= w_next_state[ch];
        r_samples_data[ch*DATA_WIDTH +: DATA_WIDTH] <= w_forward[ch] ?
            i_adc_samples_data[ch*DATA_WIDTH +: DATA_WIDTH] : '0;
        // Timestamp carries the index before this word's increment: the burst's first slot.
        r_ts_data[ch*TSTAMP_WIDTH +: TSTAMP_WIDTH] <= w_trigger[ch] ?
            {r_index[ch], r_timer} : '0;
        if (w_forward[ch]) r_index[ch] <= r_index[ch] + INDEX_ONE;
      end
    end
  end

  assign o_adc_samples_data     = r_samples_data;
  assign o_adc_samples_valid    = r_samples_valid;
  assign o_adc_timestamps_data  = r_ts_data;
  assign o_adc_timestamps_valid = r_ts_valid;

endmodule

// File: tb/tb_sample_discriminator.sv
// Directed and randomised checks of sample_discriminator against a small behavioural
// model, plus a narrow-width instance that exercises timer and index wrap.
module tb_sample_discriminator;

  localparam int SW = 16;
  localparam int PS = 2;
  localparam int CH = 8;
  localparam int TW = 64;
  localparam int IW = 16;
  localparam int DW = SW * PS;

  logic              clock = 1'b0;
  logic              reset;
  logic [CH*DW-1:0]  inData;
  logic [CH-1:0]     inValid;
  logic [CH*2*SW-1:0] thresholds;
  logic              discReset;
  logic [CH*DW-1:0]  outData;
  logic [CH-1:0]     outValid;
  logic [CH*TW-1:0]  tsData;
  logic [CH-1:0]     tsValid;

  // Narrow instance: 5-bit timer, 3-bit index, single channel.
  logic [DW-1:0] wInData;
  logic [0:0]    wInValid;
  logic [2*SW-1:0] wThresholds;
  logic          wDiscReset;
  logic [DW-1:0] wOutData;
  logic [0:0]    wOutValid;
  logic [7:0]    wTsData;
  logic [0:0]    wTsValid;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  sample_discriminator #(.SAMPLE_WIDTH(SW), .PARALLEL_SAMPLES(PS), .CHANNELS(CH),
                         .TSTAMP_WIDTH(TW), .SAMPLE_INDEX_WIDTH(IW)) dut (
    .i_adc_clk(clock), .i_adc_reset(reset),
    .i_adc_samples_data(inData), .i_adc_samples_valid(inValid),
    .i_adc_thresholds(thresholds), .i_adc_discriminator_reset(discReset),
    .o_adc_samples_data(outData), .o_adc_samples_valid(outValid),
    .o_adc_timestamps_data(tsData), .o_adc_timestamps_valid(tsValid));

  sample_discriminator #(.SAMPLE_WIDTH(SW), .PARALLEL_SAMPLES(PS), .CHANNELS(1),
                         .TSTAMP_WIDTH(8), .SAMPLE_INDEX_WIDTH(3)) dutWrap (
    .i_adc_clk(clock), .i_adc_reset(reset),
    .i_adc_samples_data(wInData), .i_adc_samples_valid(wInValid),
    .i_adc_thresholds(wThresholds), .i_adc_discriminator_reset(wDiscReset),
    .o_adc_samples_data(wOutData), .o_adc_samples_valid(wOutValid),
    .o_adc_timestamps_data(wTsData), .o_adc_timestamps_valid(wTsValid));

  // Stimulus words per channel and the behavioural model state.
  logic [DW-1:0] words [CH];
  logic [47:0]   mTimer;
  logic [15:0]   mIdx    [CH];
  bit            mActive [CH];
  bit            eSV [CH];
  logic [DW-1:0] eSD [CH];
  bit            eTV [CH];
  logic [TW-1:0] eTD [CH];

  // Observations collected per test for the hand-computed checks.
  int            obsWords   [CH];
  int            obsTsCount [CH];
  logic [TW-1:0] obsTsFirst [CH];
  logic [TW-1:0] obsTsLast  [CH];

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic clearObs();
    for (int c = 0; c < CH; c++) begin
      obsWords[c] = 0; obsTsCount[c] = 0; obsTsFirst[c] = '0; obsTsLast[c] = '0;
    end
  endtask

  task automatic clearWords();
    for (int c = 0; c < CH; c++) words[c] = '0;
  endtask

  function automatic logic [DW-1:0] mkWord(input int s1, input int s0);
    logic [SW-1:0] a;
    logic [SW-1:0] b;
    a = SW'(s1);
    b = SW'(s0);
    return {a, b};
  endfunction

  task automatic setThreshold(input int c, input int low, input int high);
    logic [SW-1:0] l;
    logic [SW-1:0] h;
    l = SW'(low);
    h = SW'(high);
    thresholds[c*2*SW +: 2*SW] = {l, h};
  endtask

  // Expected outputs one cycle after the word currently presented.
  task automatic modelStep(input bit v, input bit dr);
    logic signed [SW-1:0] hi, lo, smp;
    bit above, below, fwd, trig;
    for (int c = 0; c < CH; c++) begin
      eSV[c] = 0; eSD[c] = '0; eTV[c] = 0; eTD[c] = '0;
    end
    if (dr) begin
      mTimer = '0;
      for (int c = 0; c < CH; c++) begin mIdx[c] = '0; mActive[c] = 0; end
      return;
    end
    if (!v) return;
    for (int c = 0; c < CH; c++) begin
      hi = thresholds[c*2*SW +: SW];
      lo = thresholds[c*2*SW+SW +: SW];
      above = 0; below = 1;
      for (int s = 0; s < PS; s++) begin
        smp = words[c][s*SW +: SW];
        if (smp > hi) above = 1;
        if (!(smp < lo)) below = 0;
      end
      fwd = 0; trig = 0;
      if (!mActive[c]) begin
        if (above) begin mActive[c] = 1; fwd = 1; trig = 1; end
      end else if (above) fwd = 1;
      else if (below) mActive[c] = 0;
      else fwd = 1;
      if (trig) begin eTV[c] = 1; eTD[c] = {mIdx[c], mTimer}; end
      if (fwd) begin eSV[c] = 1; eSD[c] = words[c]; mIdx[c] = mIdx[c] + 16'd1; end
    end
    mTimer = mTimer + 48'd1;
  endtask

  // Presents one word per channel for a cycle and checks every channel's outputs.
  task automatic applyStimulus(input bit v, input bit dr);
    @(negedge clock);
    for (int c = 0; c < CH; c++) inData[c*DW +: DW] = words[c];
    inValid   = {CH{v}};
    discReset = dr;
    modelStep(v, dr);
    @(posedge clock);
    #1;
    for (int c = 0; c < CH; c++) begin
      checkOutput($sformatf("svalid ch%0d", c), 64'(outValid[c]), 64'(eSV[c]));
      checkOutput($sformatf("tsvalid ch%0d", c), 64'(tsValid[c]), 64'(eTV[c]));
      if (eSV[c]) checkOutput($sformatf("sdata ch%0d", c), 64'(outData[c*DW +: DW]), 64'(eSD[c]));
      if (eTV[c]) checkOutput($sformatf("tsdata ch%0d", c), tsData[c*TW +: TW], eTD[c]);
      if (outValid[c]) obsWords[c]++;
      if (tsValid[c]) begin
        if (obsTsCount[c] == 0) obsTsFirst[c] = tsData[c*TW +: TW];
        obsTsLast[c] = tsData[c*TW +: TW];
        obsTsCount[c]++;
      end
    end
  endtask

  task automatic sendOn(input int c, input logic [DW-1:0] w);
    clearWords();
    words[c] = w;
    applyStimulus(1'b1, 1'b0);
  endtask

  int            wWords = 0;
  int            wTsCount = 0;
  logic [7:0]    wTsFirst = '0;
  logic [7:0]    wTsLast = '0;

  task automatic driveWrap(input logic [DW-1:0] w);
    @(negedge clock);
    wInData  = w;
    wInValid = 1'b1;
    @(posedge clock);
    #1;
    if (wOutValid[0]) wWords++;
    if (wTsValid[0]) begin
      if (wTsCount == 0) wTsFirst = wTsData;
      wTsLast = wTsData;
      wTsCount++;
    end
  endtask

  initial begin
    reset = 1'b1; inData = '0; inValid = '0; discReset = 1'b0; thresholds = '0;
    wInData = '0; wInValid = '0; wDiscReset = 1'b0; wThresholds = '0;
    for (int c = 0; c < CH; c++) setThreshold(c, 20, 100);
    setThreshold(0, 20, 100);
    wThresholds = {16'd20, 16'd100};
    clearWords();
    clearObs();
    mTimer = '0;
    for (int c = 0; c < CH; c++) begin mIdx[c] = '0; mActive[c] = 0; end
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset svalid", 64'(outValid), 64'd0);
    checkOutput("reset tsvalid", 64'(tsValid), 64'd0);
    checkOutput("reset sdata", outData[63:0], 64'd0);
    checkOutput("reset tsdata", tsData[63:0], 64'd0);
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] burst on ch0 with hysteresis");
    sendOn(0, mkWord(0, 0));
    sendOn(0, mkWord(150, 0));
    sendOn(0, mkWord(50, 50));
    sendOn(0, mkWord(10, 10));
    sendOn(0, mkWord(60, 60));
    checkOutput("t1 words", 64'(obsWords[0]), 64'd2);
    checkOutput("t1 ts count", 64'(obsTsCount[0]), 64'd1);
    checkOutput("t1 ts", obsTsFirst[0], {16'd0, 48'd1});

    $display("[TB] two bursts on ch3");
    clearWords(); applyStimulus(1'b1, 1'b1); clearObs();
    sendOn(3, mkWord(200, 0));
    sendOn(3, mkWord(50, 50));
    sendOn(3, mkWord(60, 60));
    sendOn(3, mkWord(10, 10));
    clearWords(); applyStimulus(1'b0, 1'b0);
    sendOn(3, mkWord(0, 0));
    sendOn(3, mkWord(300, 1));
    sendOn(3, mkWord(40, 40));
    sendOn(3, mkWord(5, 5));
    checkOutput("t2 words", 64'(obsWords[3]), 64'd5);
    checkOutput("t2 ts count", 64'(obsTsCount[3]), 64'd2);
    checkOutput("t2 ts first", obsTsFirst[3], {16'd0, 48'd0});
    checkOutput("t2 ts second", obsTsLast[3], {16'd3, 48'd5});

    $display("[TB] discriminator reset mid-burst on ch5");
    clearWords(); applyStimulus(1'b1, 1'b1);
    sendOn(5, mkWord(150, 0));
    sendOn(5, mkWord(50, 50));
    clearWords(); words[5] = mkWord(150, 150); applyStimulus(1'b1, 1'b1);
    clearObs();
    sendOn(5, mkWord(0, 0));
    clearWords(); applyStimulus(1'b0, 1'b0);
    sendOn(5, mkWord(50, 50));
    sendOn(5, mkWord(60, 60));
    sendOn(5, mkWord(150, 0));
    checkOutput("t3 words", 64'(obsWords[5]), 64'd1);
    checkOutput("t3 ts count", 64'(obsTsCount[5]), 64'd1);
    checkOutput("t3 ts", obsTsLast[5], {16'd0, 48'd3});

    $display("[TB] inverted thresholds on ch1");
    clearWords(); applyStimulus(1'b1, 1'b1); clearObs();
    setThreshold(1, 200, 100);
    sendOn(1, mkWord(150, 0));
    sendOn(1, mkWord(150, 150));
    sendOn(1, mkWord(50, 50));
    sendOn(1, mkWord(150, 0));
    checkOutput("t4 words", 64'(obsWords[1]), 64'd3);
    checkOutput("t4 ts count", 64'(obsTsCount[1]), 64'd2);
    checkOutput("t4 ts second", obsTsLast[1], {16'd2, 48'd3});
    setThreshold(1, 20, 100);

    $display("[TB] random gaps, all channels");
    clearWords(); applyStimulus(1'b1, 1'b1);
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < CH; c++)
        words[c] = mkWord(int'($urandom_range(0, 300)) - 50, int'($urandom_range(0, 300)) - 50);
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
    end

    $display("[TB] timer and index wrap on narrow instance");
    @(negedge clock);
    inValid = '0;
    for (int n = 0; n < 33; n++) driveWrap(mkWord(0, 0));
    driveWrap(mkWord(150, 0));
    for (int n = 0; n < 8; n++) driveWrap(mkWord(50, 150));
    driveWrap(mkWord(10, 10));
    driveWrap(mkWord(0, 120));
    driveWrap(mkWord(10, 10));
    @(negedge clock);
    wInValid = 1'b0;
    checkOutput("t6 ts first", 64'(wTsFirst), 64'h01);
    checkOutput("t6 ts second", 64'(wTsLast), 64'h2B);
    checkOutput("t6 ts count", 64'(wTsCount), 64'd2);
    checkOutput("t6 words", 64'(wWords), 64'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
